bbs_bit_packer: RTL and testbench

- Downstream consumer of the BBS generator.
- On each new state strobe (the BBS write-enable), takes the K least-significant bits of the new state, which are the cryptographically usable bits, and packs them LSB-first into OUT_W-bit words.
- Buffers completed words in a DEPTH-entry FIFO and presents them on a valid/ready output port.
- The BBS core cannot stall, so the packer never back-pressures upstream. It drops complete words on FIFO overflow and flags the drop.

---
 rtl/bbs_bit_packer.sv | 160 ++++++++++++++++
 tb/tb_bbs_bit_packer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bbs_bit_packer.sv
// ---------------------------------------------------------------------------
// bbs_bit_packer
//
// Collects the K low-order (cryptographically usable) bits of each new BBS
// state and packs them LSB-first into OUT_W-bit words. Finished words go into
// a DEPTH-entry FIFO that is read through a valid/ready port. The BBS core
// cannot be stalled, so the packer never back-pressures upstream. When the
// FIFO is full it drops the finished word and raises a sticky overflow flag.
//
// Parameters:
//   W      width of the BBS state input
//   K      bits taken from each state (1..W); OUT_W must be a multiple of K
//   OUT_W  packed output word width
//   DEPTH  FIFO depth in words; must be a power of two and at least 2
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset; clears all state
//   clear       synchronous flush of accumulator, FIFO and overflow
//   in_valid    one-cycle strobe: in_state holds a new BBS state
//   in_state    BBS state value
//   out_valid   FIFO is not empty
//   out_ready   consumer takes out_word this cycle
//   out_word    FIFO head word (0 when out_valid is low)
//   overflow    sticky: at least one finished word was dropped
//   fill_level  number of words held in the FIFO (0..DEPTH)
// ---------------------------------------------------------------------------
module bbs_bit_packer #(
    parameter int W     = 16,
    parameter int K     = 1,
    parameter int OUT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_state,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_word,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(OUT_W + 1);

    // The slice that arrives when nbits has this value completes a word.
    localparam logic [CW-1:0] LAST_NBITS = CW'(OUT_W - K);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    nbits_q, nbits_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]    fill_q, fill_d;
    logic             overflow_q, overflow_d;
    logic [OUT_W-1:0] mem_q [DEPTH];

    logic [OUT_W-1:0] slice_ext;
    logic [OUT_W-1:0] candidate;
    logic             word_done;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;
    logic             mem_we;

    // Only in_state[K-1:0] is used; fold the rest into one signal that is
    // deliberately left unused.
    logic unused_state_bits;
    assign unused_state_bits = ^in_state;

    assign slice_ext = OUT_W'(in_state[K-1:0]);
    assign candidate = acc_q | (slice_ext << nbits_q);
    assign word_done = in_valid && (nbits_q == LAST_NBITS);
    assign fifo_full = (fill_q == FULL_LEVEL);
    assign pop       = (fill_q != '0) && out_ready;
    // A full FIFO still takes the word when a pop frees a slot on the same edge.
    assign push      = word_done && (!fifo_full || pop);
    assign drop      = word_done && fifo_full && !pop;
    assign mem_we    = push && !clear;

    // NOTE: every variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        acc_d      = acc_q;
        nbits_d    = nbits_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        overflow_d = overflow_q;

        if (clear) begin
            acc_d      = '0;
            nbits_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fill_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (in_valid) begin
                if (word_done) begin
                    // The accumulator restarts even when the word is dropped,
                    // so word boundaries stay aligned with the input stream.
                    acc_d   = '0;
                    nbits_d = '0;
                end else begin
                    acc_d   = candidate;
                    nbits_d = nbits_q + CW'(K);
                end
            end

            // DEPTH is a power of two, so the pointers wrap without extra logic.
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

            case ({push, pop})
                2'b10:   fill_d = fill_q + LW'(1);
                2'b01:   fill_d = fill_q - LW'(1);
                default: fill_d = fill_q;
            endcase

            if (drop) overflow_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q      <= '0;
            nbits_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            nbits_q    <= nbits_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array has no reset. An entry is only visible after it
    // is written, and out_word is forced to 0 while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= candidate;
    end

    assign out_valid  = (fill_q != '0);
    assign out_word   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow   = overflow_q;
    assign fill_level = fill_q;

endmodule

// File: tb/tb_bbs_bit_packer.sv
module tb_bbs_bit_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // DUT 1: defaults (K=1, OUT_W=8, DEPTH=4)
    logic        clear1, in_valid1, out_ready1;
    logic [15:0] in_state1;
    logic        out_valid1, overflow1;
    logic [7:0]  out_word1;
    logic [2:0]  fill1;

    // DUT 2: K=2
    logic        clear2, in_valid2, out_ready2;
    logic [15:0] in_state2;
    logic        out_valid2, overflow2;
    logic [7:0]  out_word2;
    logic [2:0]  fill2;

    bbs_bit_packer u_dut1 (
        .clk(clk), .reset(reset), .clear(clear1), .in_valid(in_valid1),
        .in_state(in_state1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_word(out_word1), .overflow(overflow1), .fill_level(fill1)
    );

    bbs_bit_packer #(.W(16), .K(2), .OUT_W(8), .DEPTH(4)) u_dut2 (
        .clk(clk), .reset(reset), .clear(clear2), .in_valid(in_valid2),
        .in_state(in_state2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_word(out_word2), .overflow(overflow2), .fill_level(fill2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic v, input logic [2:0] f,
                          input logic o, input logic [7:0] w);
        check({tag, " out_valid"}, out_valid1, v);
        check({tag, " fill_level"}, fill1, f);
        check({tag, " overflow"}, overflow1, o);
        if (v) check({tag, " out_word"}, out_word1, w);
    endtask

    // Eight back-to-back strobes on DUT 1 carrying the bits of w, LSB first.
    // out_ready is held at 0 except on the completing strobe, where it is last_ready.
    task automatic push_word(input logic [7:0] w, input logic last_ready);
        for (int i = 0; i < 8; i++) begin
            in_valid1  = 1'b1;
            in_state1  = (16'($urandom) & 16'hFFFE) | 16'(w[i]);
            out_ready1 = (i == 7) ? last_ready : 1'b0;
            step();
        end
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
    endtask

    typedef struct {
        logic       in_valid;
        logic       lsb;
        logic       out_ready;
        logic       exp_valid;
        logic [2:0] exp_fill;
        logic [7:0] exp_word;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[17];
    int   strobe_bits[8] = '{1, 0, 1, 1, 0, 0, 0, 1};

    logic [7:0] ovf_words[5]  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [2:0] ovf_fill[5]   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [7:0] full_drain[4] = '{8'h22, 8'h33, 8'h44, 8'h55};
    logic [15:0] k2_states[4] = '{16'h1233, 16'hFFF1, 16'h0002, 16'hABCC};

    initial begin
        // Table for the basic K=1 test: strobes on even rows, idle cycles between.
        for (int i = 0; i < 8; i++) begin
            vecs[2*i]   = '{in_valid: 1'b1, lsb: strobe_bits[i][0], out_ready: 1'b1,
                            exp_valid: 1'b0, exp_fill: 3'd0, exp_word: 8'h00, exp_ovf: 1'b0};
            vecs[2*i+1] = '{in_valid: 1'b0, lsb: 1'b0, out_ready: 1'b1,
                            exp_valid: 1'b0, exp_fill: 3'd0, exp_word: 8'h00, exp_ovf: 1'b0};
        end
        // The 8th strobe completes 0x8D; it is visible for exactly one cycle.
        vecs[14].exp_valid = 1'b1;
        vecs[14].exp_fill  = 3'd1;
        vecs[14].exp_word  = 8'h8D;
        vecs[16] = '{in_valid: 1'b0, lsb: 1'b0, out_ready: 1'b1,
                     exp_valid: 1'b0, exp_fill: 3'd0, exp_word: 8'h00, exp_ovf: 1'b0};

        reset = 1'b0;
        clear1 = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_state1 = '0;
        clear2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0; in_state2 = '0;
        #2;
        check("reset out_valid", out_valid1, 1'b0);
        check("reset fill_level", fill1, 3'd0);
        check("reset overflow", overflow1, 1'b0);
        check("reset out_word", out_word1, 8'h00);
        check("reset k2 out_valid", out_valid2, 1'b0);
        reset = 1'b1;
        step();

        // ---- Basic K=1 packing, table-driven ----
        for (int i = 0; i < 17; i++) begin
            in_valid1  = vecs[i].in_valid;
            in_state1  = (16'($urandom) & 16'hFFFE) | 16'(vecs[i].lsb);
            out_ready1 = vecs[i].out_ready;
            step();
            check1($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_fill,
                   vecs[i].exp_ovf, vecs[i].exp_word);
        end
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;

        // ---- K=2 packing: slices 3,1,2,0 -> 0x27 ----
        for (int i = 0; i < 4; i++) begin
            in_valid2 = 1'b1;
            in_state2 = k2_states[i];
            step();
            in_valid2 = 1'b0;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check("k2 out_valid", out_valid2, 1'b1);
            check("k2 fill_level", fill2, 3'd1);
            check("k2 out_word", out_word2, 8'h27);
            step();
        end
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
        check("k2 popped fill_level", fill2, 3'd0);
        check("k2 popped out_valid", out_valid2, 1'b0);

        // ---- Overflow: 5 words with no consumer ----
        for (int n = 0; n < 5; n++) begin
            push_word(ovf_words[n], 1'b0);
            check($sformatf("ovf fill after word %0d", n + 1), fill1, ovf_fill[n]);
            check($sformatf("ovf flag after word %0d", n + 1), overflow1, (n == 4));
        end
        out_ready1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            check("ovf drain out_valid", out_valid1, 1'b1);
            check($sformatf("ovf drain word %0d", n), out_word1, ovf_words[n]);
            step();
        end
        out_ready1 = 1'b0;
        check("ovf drained out_valid", out_valid1, 1'b0);
        check("ovf sticky", overflow1, 1'b1);
        clear1 = 1'b1;
        step();
        clear1 = 1'b0;
        check("ovf cleared", overflow1, 1'b0);

        // ---- Full FIFO with simultaneous pop and push ----
        push_word(8'h11, 1'b0);
        push_word(8'h22, 1'b0);
        push_word(8'h33, 1'b0);
        push_word(8'h44, 1'b0);
        check("full fill_level", fill1, 3'd4);
        push_word(8'h55, 1'b1);
        check("full+pop fill_level", fill1, 3'd4);
        check("full+pop overflow", overflow1, 1'b0);
        out_ready1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            check($sformatf("full drain word %0d", n), out_word1, full_drain[n]);
            step();
        end
        out_ready1 = 1'b0;
        check("full drained fill_level", fill1, 3'd0);

        // ---- Asynchronous reset mid-operation ----
        push_word(8'hA5, 1'b0);
        push_word(8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid1 = 1'b1;
            in_state1 = 16'hFFFF;
            step();
        end
        in_valid1 = 1'b0;
        check("pre-reset fill_level", fill1, 3'd2);
        #2 reset = 1'b0;
        #1;
        check("async reset out_valid", out_valid1, 1'b0);
        check("async reset fill_level", fill1, 3'd0);
        check("async reset overflow", overflow1, 1'b0);
        check("async reset out_word", out_word1, 8'h00);
        #2 reset = 1'b1;
        step();
        push_word(8'h96, 1'b0);
        check("post-reset fill_level", fill1, 3'd1);
        check("post-reset out_word", out_word1, 8'h96);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        check("post-reset popped", out_valid1, 1'b0);

        // ---- clear with a strobe and a pop on the same cycle ----
        for (int n = 0; n < 5; n++) push_word(8'hC3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid1 = 1'b1;
            in_state1 = 16'h0001;
            step();
        end
        check("pre-clear overflow", overflow1, 1'b1);
        clear1     = 1'b1;
        in_valid1  = 1'b1;
        in_state1  = 16'h0001;
        out_ready1 = 1'b1;
        step();
        clear1     = 1'b0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        check("clear fill_level", fill1, 3'd0);
        check("clear out_valid", out_valid1, 1'b0);
        check("clear overflow", overflow1, 1'b0);
        push_word(8'h5A, 1'b0);
        check("post-clear fill_level", fill1, 3'd1);
        check("post-clear out_word", out_word1, 8'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
